// File: rtl/bus_drive_arbiter.sv
// Round-robin arbiter handing one shared bus to N tri-state buffer banks, with
// guard dead-time around every drive window and a HOLD_MAX limit per window.
module bus_drive_arbiter #(
   parameter int N        = 4,
   parameter int GUARD    = 2,
   parameter int HOLD_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         oe_n,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] owner,
   output logic                 bus_idle,
   output logic                 timeout
);

   // state | meaning
   // IDLE  | bus released, all oe_n high, waiting for any request
   // SETUP | owner chosen, gnt high, GUARD cycles before its buffer turns on
   // DRIVE | oe_n[owner] low, counting hold cycles up to HOLD_MAX
   // TURN  | buffer off, gnt low, GUARD cycles before the next arbitration

   localparam int OW = $clog2(N);
   localparam int HW = ($clog2(HOLD_MAX + 1) < 8) ? 8 : $clog2(HOLD_MAX + 1);
   localparam int GW = ($clog2(GUARD + 1) < 1) ? 1 : $clog2(GUARD + 1);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRIVE, S_TURN} state_t;

   state_t        state;
   logic [OW-1:0] ptr;
   logic [OW-1:0] winner;
   logic [GW-1:0] guard_cnt;
   logic [HW-1:0] hold_cnt;

   // Walk downward so the last hit written is the nearest index after ptr.
   always_comb begin
      logic [OW-1:0] idx;
      idx    = '0;
      winner = ptr;
      for (int i = N; i >= 1; i--) begin
         idx = OW'((int'(ptr) + i) % N);
         if (req[idx]) winner = idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         oe_n      <= '1;
         gnt       <= '0;
         owner     <= '0;
         bus_idle  <= 1'b1;
         timeout   <= 1'b0;
         hold_cnt  <= '0;
         guard_cnt <= '0;
         ptr       <= OW'(N - 1);
      end else begin
         timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  state     <= S_SETUP;
                  owner     <= winner;
                  ptr       <= winner;
                  gnt       <= ONE << winner;
                  guard_cnt <= GW'(GUARD - 1);
                  bus_idle  <= 1'b0;
               end
            end
            S_SETUP: begin
               if (!req[owner]) begin
                  state     <= S_TURN;
                  gnt       <= '0;
                  guard_cnt <= GW'(GUARD - 1);
               end else if (guard_cnt == '0) begin
                  state    <= S_DRIVE;
                  oe_n     <= ~(ONE << owner);
                  hold_cnt <= HW'(1);
               end else begin
                  guard_cnt <= guard_cnt - 1'b1;
               end
            end
            S_DRIVE: begin
               // A release on the limit edge wins over the timeout flag.
               if (!req[owner] || hold_cnt == HW'(HOLD_MAX)) begin
                  state     <= S_TURN;
                  oe_n      <= '1;
                  gnt       <= '0;
                  guard_cnt <= GW'(GUARD - 1);
                  timeout   <= req[owner];
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            S_TURN: begin
               if (guard_cnt == '0) begin
                  state    <= S_IDLE;
                  bus_idle <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  guard_cnt <= guard_cnt - 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               oe_n     <= '1;
               gnt      <= '0;
               bus_idle <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Directed bench for bus_drive_arbiter at N=4, GUARD=2, HOLD_MAX=16.
module tb_bus_drive_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'h0;
   logic [3:0] oe_n;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic       bus_idle;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   bus_drive_arbiter #(.N(4), .GUARD(2), .HOLD_MAX(16)) dut (
      .clk(clk), .rst(rst), .req(req), .oe_n(oe_n), .gnt(gnt),
      .owner(owner), .bus_idle(bus_idle), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'h0;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_oe(input logic [3:0] exp, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (oe_n === exp) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'hF;
      step();
      step();
      checks++; if (oe_n !== 4'hF) begin errors++; $display("FAIL reset_oe_n: got %b expected 1111", oe_n); end
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
      checks++; if (bus_idle !== 1'b1) begin errors++; $display("FAIL reset_bus_idle: got %b expected 1", bus_idle); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      rst = 1'b0;
      req = 4'h0;
      step();
   endtask

   task automatic test_basic();
      req = 4'b0001;
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt_e0: got %b expected 0001", gnt); end
      checks++; if (oe_n !== 4'hF) begin errors++; $display("FAIL basic_oe_e0: got %b expected 1111", oe_n); end
      checks++; if (bus_idle !== 1'b0) begin errors++; $display("FAIL basic_idle_e0: got %b expected 0", bus_idle); end
      step();
      checks++; if (oe_n !== 4'hF) begin errors++; $display("FAIL basic_oe_e1: got %b expected 1111", oe_n); end
      step();
      checks++; if (oe_n !== 4'b1110) begin errors++; $display("FAIL basic_oe_e2: got %b expected 1110", oe_n); end
      step();
      step();
      step();
      checks++; if (oe_n !== 4'b1110) begin errors++; $display("FAIL basic_oe_e5: got %b expected 1110", oe_n); end
      req = 4'b0000;
      step();
      checks++; if (oe_n !== 4'hF) begin errors++; $display("FAIL basic_oe_e6: got %b expected 1111", oe_n); end
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL basic_gnt_e6: got %b expected 0000", gnt); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout_e6: got %b expected 0", timeout); end
      step();
      checks++; if (bus_idle !== 1'b0) begin errors++; $display("FAIL basic_idle_e7: got %b expected 0", bus_idle); end
      step();
      checks++; if (bus_idle !== 1'b1) begin errors++; $display("FAIL basic_idle_e8: got %b expected 1", bus_idle); end
   endtask

   task automatic test_round_robin();
      int         order [5];
      int         exp_order [5] = '{0, 1, 2, 3, 0};
      int         ng = 0;
      int         nw = 0;
      int         dcnt = 0;
      int         gap = 0;
      bit         seen = 1'b0;
      bit         multi = 1'b0;
      bit         gap_bad = 1'b0;
      logic [3:0] prev_gnt = 4'h0;
      logic [3:0] prev_oe = 4'hF;
      do_reset();
      req = 4'hF;
      for (int cyc = 0; cyc < 300 && nw < 5; cyc++) begin
         step();
         if ($countones(~oe_n) > 1) multi = 1'b1;
         if (gnt != 4'h0 && prev_gnt == 4'h0) begin
            if (ng < 5) order[ng] = int'(owner);
            ng++;
         end
         if (oe_n != 4'hF) begin
            if (prev_oe == 4'hF && seen && gap != 5) gap_bad = 1'b1;
            seen = 1'b1;
            dcnt++;
            if (dcnt == 3) req[owner] = 1'b0;
            gap = 0;
         end else begin
            if (prev_oe != 4'hF) begin
               req = 4'hF;
               nw++;
            end
            dcnt = 0;
            gap++;
         end
         prev_gnt = gnt;
         prev_oe  = oe_n;
      end
      checks++; if (nw != 5) begin errors++; $display("FAIL rr_windows: got %0d expected 5", nw); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (order[i] != exp_order[i]) begin
            errors++;
            $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
         end
      end
      checks++; if (multi) begin errors++; $display("FAIL rr_onehot_oe: got two oe_n low expected at most one"); end
      checks++; if (gap_bad) begin errors++; $display("FAIL rr_gap: got gap other than 5 expected 5 all-high cycles"); end
      req = 4'h0;
      repeat (6) step();
   endtask

   task automatic test_timeout();
      bit ok;
      int cnt = 0;
      do_reset();
      req = 4'b0100;
      wait_oe(4'b1011, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_drive_start: got %b expected 1011", oe_n); end
      while (oe_n === 4'b1011 && cnt < 40) begin
         cnt++;
         step();
      end
      checks++; if (cnt != 16) begin errors++; $display("FAIL to_drive_len: got %0d expected 16", cnt); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout); end
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL to_gnt_clear: got %b expected 0000", gnt); end
      step();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got %b expected 0", timeout); end
      step();
      checks++; if (bus_idle !== 1'b1) begin errors++; $display("FAIL to_idle: got %b expected 1", bus_idle); end
      step();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL to_regrant_gnt: got %b expected 0100", gnt); end
      checks++; if (owner !== 2'd2) begin errors++; $display("FAIL to_regrant_owner: got %0d expected 2", owner); end
      req = 4'h0;
      repeat (6) step();
   endtask

   task automatic test_abort();
      bit oe_bad = 1'b0;
      bit to_bad = 1'b0;
      req = 4'b0010;
      step();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ab_gnt: got %b expected 0010", gnt); end
      checks++; if (owner !== 2'd1) begin errors++; $display("FAIL ab_owner: got %0d expected 1", owner); end
      req = 4'h0;
      step();
      if (oe_n !== 4'hF) oe_bad = 1'b1;
      if (timeout !== 1'b0) to_bad = 1'b1;
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL ab_gnt_clear: got %b expected 0000", gnt); end
      checks++; if (bus_idle !== 1'b0) begin errors++; $display("FAIL ab_turn1: got %b expected 0", bus_idle); end
      step();
      if (oe_n !== 4'hF) oe_bad = 1'b1;
      if (timeout !== 1'b0) to_bad = 1'b1;
      checks++; if (bus_idle !== 1'b0) begin errors++; $display("FAIL ab_turn2: got %b expected 0", bus_idle); end
      step();
      if (oe_n !== 4'hF) oe_bad = 1'b1;
      if (timeout !== 1'b0) to_bad = 1'b1;
      checks++; if (bus_idle !== 1'b1) begin errors++; $display("FAIL ab_idle: got %b expected 1", bus_idle); end
      checks++; if (oe_bad) begin errors++; $display("FAIL ab_oe_never_low: got low expected 1111"); end
      checks++; if (to_bad) begin errors++; $display("FAIL ab_no_timeout: got 1 expected 0"); end
   endtask

   task automatic test_rst_drive();
      bit ok;
      do_reset();
      req = 4'b1000;
      wait_oe(4'b0111, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rd_drive: got %b expected 0111", oe_n); end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (oe_n !== 4'hF) begin errors++; $display("FAIL rd_oe: got %b expected 1111", oe_n); end
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL rd_gnt: got %b expected 0000", gnt); end
      checks++; if (bus_idle !== 1'b1) begin errors++; $display("FAIL rd_idle: got %b expected 1", bus_idle); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rd_timeout: got %b expected 0", timeout); end
      req = 4'b1001;
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rd_first_gnt: got %b expected 0001", gnt); end
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rd_first_owner: got %0d expected 0", owner); end
      req = 4'h0;
      repeat (6) step();
   endtask

   task automatic test_same_edge();
      bit ok;
      do_reset();
      req = 4'b0100;
      wait_oe(4'b1011, ok);
      checks++; if (!ok) begin errors++; $display("FAIL se_drive: got %b expected 1011", oe_n); end
      repeat (15) step();
      checks++; if (oe_n !== 4'b1011) begin errors++; $display("FAIL se_cycle16: got %b expected 1011", oe_n); end
      req = 4'h0;
      step();
      checks++; if (oe_n !== 4'hF) begin errors++; $display("FAIL se_release: got %b expected 1111", oe_n); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL se_timeout: got %b expected 0", timeout); end
      step();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL se_timeout_late: got %b expected 0", timeout); end
      repeat (4) step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_abort();
      test_rst_drive();
      test_same_edge();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
